// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with look-ahead fetch coordinate and line/frame strobes.
// Latency: pix_en is combinational from the divider; every other output lags the counters by 1 clock.
// Backpressure: none; free-running. Optional sticky frame flag when VGA_FRAME_IRQ_EN is defined.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int H_POL      = 0,
  parameter int V_POL      = 0,
  parameter int CLK_DIV    = 2,
  parameter int FETCH_LEAD = 2,
  parameter int CNT_W      = 10
) (
  input  logic             clock,
  input  logic             clear,
  output logic             pix_en,
  output logic             hSync,
  output logic             vSync,
  output logic             bright,
  output logic [CNT_W-1:0] hCount,
  output logic [CNT_W-1:0] vCount,
  output logic [CNT_W-1:0] fetch_x,
  output logic [CNT_W-1:0] fetch_y,
  output logic             fetch_valid,
  output logic             line_start,
`ifdef VGA_FRAME_IRQ_EN
  output logic             frame_start,
  output logic             irq,
  input  logic             irq_ack
`else
  output logic             frame_start
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS_LAST = CNT_W'(H_VISIBLE - 1);
  localparam logic [CNT_W-1:0] V_VIS_LAST = CNT_W'(V_VISIBLE - 1);

  // Comparisons run one bit wider so H_TOTAL == 2^CNT_W still fits.
  localparam logic [CNT_W:0] H_TOT_X  = (CNT_W+1)'(H_TOTAL);
  localparam logic [CNT_W:0] H_VIS_X  = (CNT_W+1)'(H_VISIBLE);
  localparam logic [CNT_W:0] V_VIS_X  = (CNT_W+1)'(V_VISIBLE);
  localparam logic [CNT_W:0] HS_BEG_X = (CNT_W+1)'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W:0] HS_END_X = (CNT_W+1)'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W:0] VS_BEG_X = (CNT_W+1)'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W:0] VS_END_X = (CNT_W+1)'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [CNT_W:0] LEAD_X   = (CNT_W+1)'(FETCH_LEAD);

  localparam logic H_ACT = (H_POL != 0);
  localparam logic V_ACT = (V_POL != 0);

  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_h;
  logic [CNT_W-1:0] r_v;
  logic             r_adv;      // counters moved on the previous clock

  logic [CNT_W-1:0] r_hcount;
  logic [CNT_W-1:0] r_vcount;
  logic [CNT_W-1:0] r_fetch_x;
  logic [CNT_W-1:0] r_fetch_y;
  logic             r_fetch_valid;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_bright;
  logic             r_line_start;
  logic             r_frame_start;

  logic             w_pix_en;
  logic [CNT_W:0]   w_h_x;
  logic [CNT_W:0]   w_v_x;
  logic [CNT_W:0]   w_sum;
  logic [CNT_W:0]   w_sum_wrap;
  logic             w_wrap;
  logic [CNT_W-1:0] w_v_next;
  logic [CNT_W-1:0] w_fx;
  logic [CNT_W-1:0] w_fy;
  logic             w_fvalid;
  logic             w_hs_act;
  logic             w_vs_act;
  logic             w_bright;

  assign w_pix_en = (r_div == DIV_LAST);

  // Clock divider: one pixel advance every CLK_DIV clocks
  always_ff @(posedge clock) begin
    if (clear) begin
      r_div <= '0;
    end else if (w_pix_en) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Raster counters: h wraps at end of line and carries into v
  always_ff @(posedge clock) begin
    if (clear) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_pix_en) begin
      if (r_h == H_LAST) begin
        r_h <= '0;
        r_v <= (r_v == V_LAST) ? '0 : r_v + CNT_W'(1);
      end else begin
        r_h <= r_h + CNT_W'(1);
      end
    end
  end

  // Remember an advance so the strobes fire only on the first clock of a new position
  always_ff @(posedge clock) begin
    if (clear) begin
      r_adv <= 1'b0;
    end else begin
      r_adv <= w_pix_en;
    end
  end

  assign w_h_x      = {1'b0, r_h};
  assign w_v_x      = {1'b0, r_v};
  assign w_sum      = w_h_x + LEAD_X;
  assign w_sum_wrap = w_sum - H_TOT_X;
  assign w_wrap     = (w_sum >= H_TOT_X);
  assign w_v_next   = (r_v == V_LAST) ? '0 : r_v + CNT_W'(1);
  assign w_fx       = w_wrap ? w_sum_wrap[CNT_W-1:0] : w_sum[CNT_W-1:0];
  assign w_fy       = w_wrap ? w_v_next : r_v;
  assign w_fvalid   = ({1'b0, w_fx} < H_VIS_X) && ({1'b0, w_fy} < V_VIS_X);
  assign w_hs_act   = (w_h_x >= HS_BEG_X) && (w_h_x < HS_END_X);
  assign w_vs_act   = (w_v_x >= VS_BEG_X) && (w_v_x < VS_END_X);
  assign w_bright   = (w_h_x < H_VIS_X) && (w_v_x < V_VIS_X);

  // Register every pixel-path output from the counter state
  always_ff @(posedge clock) begin
    if (clear) begin
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_fetch_x     <= '0;
      r_fetch_y     <= '0;
      r_fetch_valid <= 1'b0;
      r_hsync       <= ~H_ACT;
      r_vsync       <= ~V_ACT;
      r_bright      <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hcount      <= r_h;
      r_vcount      <= r_v;
      r_fetch_x     <= w_fx;
      r_fetch_y     <= w_fy;
      r_fetch_valid <= w_fvalid;
      r_hsync       <= w_hs_act ? H_ACT : ~H_ACT;
      r_vsync       <= w_vs_act ? V_ACT : ~V_ACT;
      r_bright      <= w_bright;
      r_line_start  <= r_adv && (r_h == '0);
      r_frame_start <= r_adv && (r_h == '0) && (r_v == '0);
    end
  end

  assign pix_en      = w_pix_en;
  assign hCount      = r_hcount;
  assign vCount      = r_vcount;
  assign fetch_x     = r_fetch_x;
  assign fetch_y     = r_fetch_y;
  assign fetch_valid = r_fetch_valid;
  assign hSync       = r_hsync;
  assign vSync       = r_vsync;
  assign bright      = r_bright;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

`ifdef VGA_FRAME_IRQ_EN
  logic r_irq;

  // Sticky flag raised when the last visible pixel is passed; a set beats a same-clock ack
  always_ff @(posedge clock) begin
    if (clear) begin
      r_irq <= 1'b0;
    end else if (w_pix_en && (r_h == H_VIS_LAST) && (r_v == V_VIS_LAST)) begin
      r_irq <= 1'b1;
    end else if (irq_ack) begin
      r_irq <= 1'b0;
    end
  end

  assign irq = r_irq;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: directed expectations keyed by clocks since clear release.
// Three instances: default timing (lead 4), a tiny raster for frame-level checks, 800x600 positive sync.
// A negedge monitor pops every expectation whose clock index matches and compares it.
module tb_vga_timing_gen;

  typedef enum int {S_PE, S_HC, S_VC, S_HS, S_VS, S_BR, S_FX, S_FY, S_FV,
                    S_LS, S_FS, S_IRQ, S_HSLOW} sig_e;

  typedef struct {
    int   dut;
    int   k;
    sig_e sig;
    int   exp;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cnt [3];
  int   obs [3][13];
  int   hs_low_a = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr_a, clr_b, clr_c;
  logic pe_a, hs_a, vs_a, br_a, fv_a, ls_a, fs_a;
  logic pe_b, hs_b, vs_b, br_b, fv_b, ls_b, fs_b;
  logic pe_c, hs_c, vs_c, br_c, fv_c, ls_c, fs_c;
  logic [9:0]  hc_a, vc_a, fx_a, fy_a;
  logic [9:0]  hc_b, vc_b, fx_b, fy_b;
  logic [10:0] hc_c, vc_c, fx_c, fy_c;
`ifdef VGA_FRAME_IRQ_EN
  logic irq_a, irq_b, irq_c;
  logic ack_a = 1'b0;
  logic ack_b = 1'b0;
  logic ack_c = 1'b0;
`endif

  vga_timing_gen #(.FETCH_LEAD(4)) u_a (
    .clock(clk), .clear(clr_a), .pix_en(pe_a), .hSync(hs_a), .vSync(vs_a), .bright(br_a),
    .hCount(hc_a), .vCount(vc_a), .fetch_x(fx_a), .fetch_y(fy_a), .fetch_valid(fv_a),
    .line_start(ls_a), .frame_start(fs_a)
`ifdef VGA_FRAME_IRQ_EN
    , .irq(irq_a), .irq_ack(ack_a)
`endif
  );

  vga_timing_gen #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
                   .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
                   .FETCH_LEAD(4)) u_b (
    .clock(clk), .clear(clr_b), .pix_en(pe_b), .hSync(hs_b), .vSync(vs_b), .bright(br_b),
    .hCount(hc_b), .vCount(vc_b), .fetch_x(fx_b), .fetch_y(fy_b), .fetch_valid(fv_b),
    .line_start(ls_b), .frame_start(fs_b)
`ifdef VGA_FRAME_IRQ_EN
    , .irq(irq_b), .irq_ack(ack_b)
`endif
  );

  vga_timing_gen #(.H_VISIBLE(800), .H_FRONT(40), .H_SYNC(128), .H_BACK(88),
                   .V_VISIBLE(600), .V_FRONT(1), .V_SYNC(4), .V_BACK(23),
                   .H_POL(1), .V_POL(1), .CLK_DIV(1), .CNT_W(11)) u_c (
    .clock(clk), .clear(clr_c), .pix_en(pe_c), .hSync(hs_c), .vSync(vs_c), .bright(br_c),
    .hCount(hc_c), .vCount(vc_c), .fetch_x(fx_c), .fetch_y(fy_c), .fetch_valid(fv_c),
    .line_start(ls_c), .frame_start(fs_c)
`ifdef VGA_FRAME_IRQ_EN
    , .irq(irq_c), .irq_ack(ack_c)
`endif
  );

  // Clocks since each instance's clear was last sampled high
  always @(posedge clk) begin
    cnt[0] <= clr_a ? 0 : cnt[0] + 1;
    cnt[1] <= clr_b ? 0 : cnt[1] + 1;
    cnt[2] <= clr_c ? 0 : cnt[2] + 1;
  end

  always_comb begin
    obs = '{default: '{default: 0}};
    obs[0][S_PE] = int'(pe_a); obs[0][S_HC] = int'(hc_a); obs[0][S_VC] = int'(vc_a);
    obs[0][S_HS] = int'(hs_a); obs[0][S_VS] = int'(vs_a); obs[0][S_BR] = int'(br_a);
    obs[0][S_FX] = int'(fx_a); obs[0][S_FY] = int'(fy_a); obs[0][S_FV] = int'(fv_a);
    obs[0][S_LS] = int'(ls_a); obs[0][S_FS] = int'(fs_a); obs[0][S_HSLOW] = hs_low_a;
    obs[1][S_PE] = int'(pe_b); obs[1][S_HC] = int'(hc_b); obs[1][S_VC] = int'(vc_b);
    obs[1][S_HS] = int'(hs_b); obs[1][S_VS] = int'(vs_b); obs[1][S_BR] = int'(br_b);
    obs[1][S_FX] = int'(fx_b); obs[1][S_FY] = int'(fy_b); obs[1][S_FV] = int'(fv_b);
    obs[1][S_LS] = int'(ls_b); obs[1][S_FS] = int'(fs_b);
    obs[2][S_PE] = int'(pe_c); obs[2][S_HC] = int'(hc_c); obs[2][S_VC] = int'(vc_c);
    obs[2][S_HS] = int'(hs_c); obs[2][S_VS] = int'(vs_c); obs[2][S_BR] = int'(br_c);
    obs[2][S_FX] = int'(fx_c); obs[2][S_FY] = int'(fy_c); obs[2][S_FV] = int'(fv_c);
    obs[2][S_LS] = int'(ls_c); obs[2][S_FS] = int'(fs_c);
`ifdef VGA_FRAME_IRQ_EN
    obs[0][S_IRQ] = int'(irq_a);
    obs[1][S_IRQ] = int'(irq_b);
    obs[2][S_IRQ] = int'(irq_c);
`endif
  end

  // Monitor: compare and retire every expectation due at this clock
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].k == cnt[q[i].dut]) begin
        n_checks++;
        if (obs[q[i].dut][q[i].sig] != q[i].exp) begin
          n_fail++;
          $display("FAIL dut%0d k=%0d %s actual=%0d required=%0d",
                   q[i].dut, q[i].k, q[i].sig.name(), obs[q[i].dut][q[i].sig], q[i].exp);
        end
        q.delete(i);
      end
    end
    // Count hSync-low clocks across the first line of instance A
    if (cnt[0] == 0) hs_low_a = 0;
    else if (cnt[0] <= 1600 && !hs_a) hs_low_a++;
  end

  task automatic ex(input int d, input int k, input sig_e s, input int v);
    exp_t e;
    e.dut = d; e.k = k; e.sig = s; e.exp = v;
    q.push_back(e);
  endtask

  task automatic wait_cnt(input int d, input int target);
    int t = 0;
    while (cnt[d] != target && t < 30000) begin
      @(negedge clk);
      t++;
    end
    if (cnt[d] != target) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait dut%0d actual=%0d required=%0d", d, cnt[d], target);
    end
  endtask

  task automatic push_reset_a();
    ex(0, 0, S_PE, 0); ex(0, 0, S_HC, 0); ex(0, 0, S_VC, 0); ex(0, 0, S_HS, 1);
    ex(0, 0, S_VS, 1); ex(0, 0, S_BR, 0); ex(0, 0, S_FX, 0); ex(0, 0, S_FY, 0);
    ex(0, 0, S_FV, 0); ex(0, 0, S_LS, 0); ex(0, 0, S_FS, 0);
  endtask

  initial begin
    clr_a = 1'b1; clr_b = 1'b1; clr_c = 1'b1;
    @(posedge clk); #1;
    // Reset state of all instances
    push_reset_a();
    ex(1, 0, S_HS, 1); ex(1, 0, S_VS, 1); ex(1, 0, S_BR, 0); ex(1, 0, S_FV, 0);
    ex(1, 0, S_LS, 0); ex(1, 0, S_FS, 0);
    ex(2, 0, S_HS, 0); ex(2, 0, S_VS, 0); ex(2, 0, S_BR, 0);
    // A: default 800x525 raster, CLK_DIV 2, lead 4; k = 1 + 2*(line*800 + h)
    ex(0, 1, S_PE, 1); ex(0, 1, S_HC, 0); ex(0, 1, S_BR, 1); ex(0, 1, S_FX, 4);
    ex(0, 1, S_FV, 1); ex(0, 1, S_LS, 0); ex(0, 2, S_PE, 0); ex(0, 3, S_HC, 1);
    ex(0, 1279, S_BR, 1); ex(0, 1281, S_BR, 0); ex(0, 1281, S_HC, 640);
    ex(0, 1311, S_HS, 1); ex(0, 1313, S_HS, 0); ex(0, 1313, S_HC, 656);
    ex(0, 1314, S_HS, 0); ex(0, 1503, S_HS, 0); ex(0, 1505, S_HS, 1);
    ex(0, 1593, S_FX, 0); ex(0, 1593, S_FY, 1); ex(0, 1593, S_FV, 1);
    ex(0, 1601, S_LS, 1); ex(0, 1601, S_HC, 0); ex(0, 1601, S_VC, 1);
    ex(0, 1601, S_FS, 0); ex(0, 1601, S_HSLOW, 192); ex(0, 1602, S_LS, 0);
    ex(0, 17597, S_HC, 798); ex(0, 17597, S_VC, 10); ex(0, 17597, S_FX, 2);
    ex(0, 17597, S_FY, 11); ex(0, 17597, S_FV, 1);
    ex(0, 18201, S_HC, 300); ex(0, 18201, S_VC, 11);
    // B: 16x11 raster, CLK_DIV 2, lead 4; k = 1 + 2*(line*16 + h)
    ex(1, 9, S_FX, 8); ex(1, 9, S_FV, 0);
    ex(1, 125, S_FX, 2); ex(1, 125, S_FY, 4); ex(1, 125, S_FV, 1);
    ex(1, 175, S_BR, 1); ex(1, 193, S_BR, 0); ex(1, 193, S_VS, 1);
    ex(1, 225, S_VS, 0); ex(1, 287, S_VS, 0); ex(1, 289, S_VS, 1);
    ex(1, 349, S_VC, 10); ex(1, 349, S_FX, 2); ex(1, 349, S_FY, 0); ex(1, 349, S_FV, 1);
    ex(1, 352, S_FS, 0); ex(1, 353, S_FS, 1); ex(1, 353, S_LS, 1);
    ex(1, 353, S_HC, 0); ex(1, 353, S_VC, 0); ex(1, 354, S_FS, 0); ex(1, 705, S_FS, 1);
`ifdef VGA_FRAME_IRQ_EN
    ex(1, 0, S_IRQ, 0); ex(1, 175, S_IRQ, 0); ex(1, 176, S_IRQ, 1);
    ex(1, 199, S_IRQ, 1); ex(1, 200, S_IRQ, 0); ex(1, 527, S_IRQ, 0);
    ex(1, 528, S_IRQ, 1); ex(1, 539, S_IRQ, 1); ex(1, 540, S_IRQ, 0);
`endif
    // C: 1056x628 raster, CLK_DIV 1, positive sync; k = 1 + line*1056 + h
    ex(2, 5, S_PE, 1); ex(2, 800, S_BR, 1); ex(2, 801, S_BR, 0);
    ex(2, 840, S_HS, 0); ex(2, 841, S_HS, 1); ex(2, 841, S_HC, 840);
    ex(2, 968, S_HS, 1); ex(2, 969, S_HS, 0);
    ex(2, 1057, S_LS, 1); ex(2, 1057, S_HC, 0); ex(2, 1057, S_VC, 1);
    ex(2, 2112, S_LS, 0); ex(2, 2113, S_LS, 1);

    @(posedge clk);
    @(negedge clk);
    clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;

    fork
      begin
        // Mid-line clear on A at line 11, h 300, held for 3 clocks
        wait_cnt(0, 18201);
        clr_a = 1'b1;
        @(posedge clk); #1;
        push_reset_a();
        ex(0, 1, S_PE, 1); ex(0, 1, S_LS, 0); ex(0, 1, S_FS, 0);
        ex(0, 2, S_PE, 0); ex(0, 2, S_HC, 0); ex(0, 3, S_HC, 1);
        ex(0, 1600, S_LS, 0); ex(0, 1601, S_LS, 1); ex(0, 1601, S_HC, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr_a = 1'b0;
      end
`ifdef VGA_FRAME_IRQ_EN
      begin
        wait_cnt(1, 199); ack_b = 1'b1; @(negedge clk); ack_b = 1'b0;
        wait_cnt(1, 527); ack_b = 1'b1; @(negedge clk); ack_b = 1'b0;
        wait_cnt(1, 539); ack_b = 1'b1; @(negedge clk); ack_b = 1'b0;
      end
`endif
    join

    for (int t = 0; t < 5000 && q.size() > 0; t++) @(negedge clk);
    foreach (q[i]) begin
      n_checks++;
      n_fail++;
      $display("FAIL expired dut%0d k=%0d %s actual=unsampled required=%0d",
               q[i].dut, q[i].k, q[i].sig.name(), q[i].exp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
